uc_seq: RTL and testbench
=========================

# uc_seq

Sequencing control unit for the single-cycle microcontroller datapath. It consumes the datapath's 6-bit `opcode` and registered `zero` flag, and drives its control lines `s_inc`, `s_inm`, `we`, `wez` and `ALUop`, plus the `pc_en` enable of the PC register. A small FSM adds a boot cycle, multi-cycle WAIT instructions, HALT, and trapping of illegal opcodes.

## Interface
- `WAIT_W`, default 4: width of the WAIT operand and cycle counter (operand = `opcode[WAIT_W-1:0]`; must be ≤ 4).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces state BOOT.
- `opcode` in 6: current instruction opcode from the datapath.
- `zero` in 1: registered ALU zero flag from the datapath.
- `s_inc` out 1: 1 = PC+1, 0 = load jump address.
- `s_inm` out 1: 1 = immediate operand / immediate register addressing.
- `we` out 1: register file write enable.
- `wez` out 1: zero flip-flop write enable.
- `ALUop` out 3: ALU operation.
- `pc_en` out 1: PC register update enable.
- `halted` out 1: high while in HALT.
- `illegal` out 1: sticky; set when HALT was entered through an illegal opcode.

## Operation
- States: BOOT, RUN, WAIT, HALT. Outputs are combinational from state, `opcode` and `zero`.
- **Default outputs** (BOOT, WAIT, HALT, and any field not set below): `s_inc`=1, `s_inm`=0, `we`=0, `wez`=0, `ALUop`=000, `pc_en`=0.
- **BOOT:** lasts exactly one cycle after reset release, then RUN. This gives the synchronous program memory its first fetch.
- **RUN decode:**
  - `00_0ccc` ALU reg: `we`=1, `wez`=1, `ALUop`=ccc, `pc_en`=1.
  - `00_1ccc` ALU imm: same as ALU reg, plus `s_inm`=1.
  - `01_0000` J: `s_inc`=0, `pc_en`=1.
  - `01_0001` JZ: `s_inc`=~`zero`, `pc_en`=1.
  - `01_0010` JNZ: `s_inc`=`zero`, `pc_en`=1.
  - `10_nnnn` WAIT n:
    - n=0 behaves as NOP: `pc_en`=1, stay in RUN.
    - n≠0: `pc_en`=0, `cnt`←n, go to WAIT.
  - `11_1111` HALT: `pc_en`=0, go to HALT.
  - All other opcodes are illegal: `pc_en`=0, `illegal`←1, go to HALT.
- **WAIT:** `cnt`←`cnt`-1 each cycle.
  - `cnt`==1: `pc_en`=1, go to RUN.
  - Otherwise: `pc_en`=0, stay in WAIT.
  - `opcode` is ignored while in WAIT.
- **HALT:** absorbing. Only `reset` exits it. `halted`=1.
- `cnt` is a `WAIT_W`-bit unsigned counter. It never wraps: it is only loaded with a nonzero value and leaves WAIT at 1.

## Timing
- Reset values:
  - state BOOT, `cnt`=0, `illegal`=0.
  - Outputs: `s_inc`=1, `s_inm`=0, `we`=0, `wez`=0, `ALUop`=000, `pc_en`=0, `halted`=0.
- Single-cycle instructions (ALU, J, JZ, JNZ, WAIT 0) occupy 1 cycle.
- WAIT n occupies n+1 cycles; the PC advances only in the last of them.
- HALT and illegal opcodes: `halted` rises the cycle after decode. `illegal` is registered and rises in the same cycle as `halted`.
- JZ/JNZ use `zero` as sampled in the decode cycle, i.e. the flag written by the previous `wez` instruction.
- `reset` asserted mid-WAIT or in HALT: outputs go to reset values immediately (asynchronously), `cnt` clears, and the unit restarts with BOOT.

## Structure
- Package `uc_pkg` holds:
  - the state enum `uc_state_t` {BOOT, RUN, WAIT, HALT};
  - opcode constants `OP_J`, `OP_JZ`, `OP_JNZ`, `OP_HALT`;
  - field prefixes `PFX_ALU_R`=3'b000, `PFX_ALU_I`=3'b001, `PFX_WAIT`=2'b10;
  - the `ALUop` reset constant.
- Sub-module `uc_decode` is the purely combinational RUN-state opcode decoder. It outputs the control bundle plus `is_wait`, `is_halt` and `is_illegal`.
- `uc_seq` holds the state register, `cnt` and `illegal`, and muxes in the defaults outside RUN.

## Test plan
- **Reset then boot:** assert `reset`, release it, `opcode`=00_0010.
  - Cycle 0 (BOOT): `pc_en`=0, `we`=0.
  - Cycle 1: `we`=1, `wez`=1, `ALUop`=010, `pc_en`=1.
- **Immediate ALU:** `opcode`=00_1101 in RUN → `s_inm`=1, `ALUop`=101, `we`=1, `pc_en`=1.
- **Branches:**
  - JZ with `zero`=1 → `s_inc`=0. JZ with `zero`=0 → `s_inc`=1.
  - JNZ with `zero`=1 → `s_inc`=1.
  - All three cases have `pc_en`=1 and `we`=0.
- **WAIT:**
  - `opcode`=10_0011 → `pc_en` sequence 0,0,0,1 over 4 cycles, `we`=0 throughout, then RUN.
  - `opcode`=10_0000 → `pc_en`=1 in a single cycle.
- **HALT and illegal:**
  - `opcode`=11_1111 → next cycle `halted`=1, `illegal`=0; stays there for 20 cycles with any opcode.
  - `opcode`=01_0110 → `halted`=1, `illegal`=1.
- **Reset mid-WAIT:** load WAIT 15, assert `reset` after 5 cycles → outputs at reset values without waiting for a clock edge, state BOOT, `cnt`=0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared types and opcode encodings for the uc_seq sequencing control unit.
package uc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } uc_state_t;

  localparam logic [5:0] OP_J    = 6'b01_0000;
  localparam logic [5:0] OP_JZ   = 6'b01_0001;
  localparam logic [5:0] OP_JNZ  = 6'b01_0010;
  localparam logic [5:0] OP_HALT = 6'b11_1111;

  localparam logic [2:0] PFX_ALU_R = 3'b000;
  localparam logic [2:0] PFX_ALU_I = 3'b001;
  localparam logic [1:0] PFX_WAIT  = 2'b10;

  localparam logic [2:0] ALUOP_RST = 3'b000;

endpackage

// File: rtl/uc_decode.sv
// Combinational RUN-state opcode decoder: control lines plus WAIT/HALT/illegal flags.
module uc_decode
  import uc_pkg::*;
#(
  parameter int WAIT_W = 4
) (
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we,
  output logic       wez,
  output logic [2:0] alu_op,
  output logic       pc_en,
  output logic       is_wait,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    we         = 1'b0;
    wez        = 1'b0;
    alu_op     = ALUOP_RST;
    pc_en      = 1'b0;
    is_wait    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;

    if (opcode[5:3] == PFX_ALU_R || opcode[5:3] == PFX_ALU_I) begin
      we     = 1'b1;
      wez    = 1'b1;
      alu_op = opcode[2:0];
      s_inm  = opcode[3];
      pc_en  = 1'b1;
    end else if (opcode == OP_J) begin
      s_inc = 1'b0;
      pc_en = 1'b1;
    end else if (opcode == OP_JZ) begin
      s_inc = ~zero;
      pc_en = 1'b1;
    end else if (opcode == OP_JNZ) begin
      s_inc = zero;
      pc_en = 1'b1;
    end else if (opcode[5:4] == PFX_WAIT) begin
      // A zero operand degenerates to a single-cycle NOP.
      if (opcode[WAIT_W-1:0] == '0) pc_en = 1'b1;
      else                          is_wait = 1'b1;
    end else if (opcode == OP_HALT) begin
      is_halt = 1'b1;
    end else begin
      is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit: BOOT/RUN/WAIT/HALT FSM around the opcode decoder.
// Outputs are combinational from state, opcode and zero; defaults outside RUN.
module uc_seq
  import uc_pkg::*;
#(
  parameter int WAIT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we,
  output logic       wez,
  output logic [2:0] ALUop,
  output logic       pc_en,
  output logic       halted,
  output logic       illegal
);

  uc_state_t         state;
  logic [WAIT_W-1:0] cnt;

  logic       d_s_inc, d_s_inm, d_we, d_wez, d_pc_en;
  logic [2:0] d_alu_op;
  logic       is_wait, is_halt, is_illegal;

  uc_decode #(.WAIT_W(WAIT_W)) u_decode (
    .opcode     (opcode),
    .zero       (zero),
    .s_inc      (d_s_inc),
    .s_inm      (d_s_inm),
    .we         (d_we),
    .wez        (d_wez),
    .alu_op     (d_alu_op),
    .pc_en      (d_pc_en),
    .is_wait    (is_wait),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= BOOT;
      cnt     <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (is_wait) begin
            cnt   <= opcode[WAIT_W-1:0];
            state <= WAIT;
          end else if (is_halt) begin
            state <= HALT;
          end else if (is_illegal) begin
            illegal <= 1'b1;
            state   <= HALT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == WAIT_W'(1)) state <= RUN;
        end
        HALT: state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we    = 1'b0;
    wez   = 1'b0;
    ALUop = ALUOP_RST;
    pc_en = 1'b0;
    if (state == RUN) begin
      s_inc = d_s_inc;
      s_inm = d_s_inm;
      we    = d_we;
      wez   = d_wez;
      ALUop = d_alu_op;
      pc_en = d_pc_en;
    end else if (state == WAIT && cnt == WAIT_W'(1)) begin
      // PC advances only in the final WAIT cycle.
      pc_en = 1'b1;
    end
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_uc_seq.sv
// Directed, table-driven self-checking bench for uc_seq.
module tb_uc_seq;
  import uc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       s_inc, s_inm, we, wez, pc_en, halted, illegal;
  logic [2:0] ALUop;

  int checks = 0;
  int errors = 0;

  uc_seq #(.WAIT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .zero    (zero),
    .s_inc   (s_inc),
    .s_inm   (s_inm),
    .we      (we),
    .wez     (wez),
    .ALUop   (ALUop),
    .pc_en   (pc_en),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Bundle order: s_inc s_inm we wez ALUop[2:0] pc_en halted illegal
  wire [9:0] outs = {s_inc, s_inm, we, wez, ALUop, pc_en, halted, illegal};

  localparam logic [9:0] DEF    = 10'b1_0_0_0_000_0_0_0;
  localparam logic [9:0] PCEN   = 10'b1_0_0_0_000_1_0_0;
  localparam logic [9:0] HALTED = 10'b1_0_0_0_000_0_1_0;
  localparam logic [9:0] ILLEG  = 10'b1_0_0_0_000_0_1_1;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [9:0] exp);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, outs, exp);
    end
  endtask

  task automatic check_regs(input string name);
    checks++;
    if (dut.state !== BOOT || dut.cnt !== 4'd0 || outs !== DEF) begin
      errors++;
      $display("FAIL %s: state=%0d cnt=%0d outs=%b expected state=0 cnt=0 outs=%b",
               name, dut.state, dut.cnt, outs, DEF);
    end
  endtask

  // Called at posedge+2: drive, check at posedge+4, advance to next posedge+2.
  task automatic cyc(input logic [5:0] op, input logic z, input logic [9:0] exp,
                     input string name);
    opcode = op;
    zero   = z;
    #2;
    check(name, exp);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{6'b00_0010, 1'b0, 10'b1_0_1_1_010_1_0_0};
    vecs[1] = '{6'b00_1101, 1'b0, 10'b1_1_1_1_101_1_0_0};
    vecs[2] = '{6'b01_0001, 1'b1, 10'b0_0_0_0_000_1_0_0};
    vecs[3] = '{6'b01_0001, 1'b0, 10'b1_0_0_0_000_1_0_0};
    vecs[4] = '{6'b01_0010, 1'b1, 10'b1_0_0_0_000_1_0_0};
    vecs[5] = '{6'b01_0010, 1'b0, 10'b0_0_0_0_000_1_0_0};
    vecs[6] = '{6'b01_0000, 1'b1, 10'b0_0_0_0_000_1_0_0};
    vecs[7] = '{6'b10_0000, 1'b0, PCEN};
    vecs[8] = '{6'b00_0111, 1'b1, 10'b1_0_1_1_111_1_0_0};
    vecs[9] = '{6'b00_1000, 1'b0, 10'b1_1_1_1_000_1_0_0};

    // Reset and boot
    opcode = 6'b00_0010;
    #3;
    check_regs("reset_state");
    @(posedge clk);
    #2;
    reset = 1'b0;
    cyc(6'b00_0010, 1'b0, DEF, "boot_cycle");
    cyc(6'b00_0010, 1'b0, 10'b1_0_1_1_010_1_0_0, "first_run");

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].op, vecs[i].z, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // WAIT 3: four cycles, opcode ignored after decode
    cyc(6'b10_0011, 1'b0, DEF,  "wait3_c0");
    cyc(6'b11_1111, 1'b0, DEF,  "wait3_c1");
    cyc(6'b01_0110, 1'b1, DEF,  "wait3_c2");
    cyc(6'b00_0001, 1'b0, PCEN, "wait3_c3");
    cyc(6'b00_1011, 1'b0, 10'b1_1_1_1_011_1_0_0, "after_wait3");

    // WAIT 1: shortest multi-cycle form
    cyc(6'b10_0001, 1'b0, DEF,  "wait1_c0");
    cyc(6'b11_1111, 1'b0, PCEN, "wait1_c1");
    cyc(6'b01_0000, 1'b0, 10'b0_0_0_0_000_1_0_0, "after_wait1");

    // HALT is absorbing
    cyc(6'b11_1111, 1'b0, DEF, "halt_decode");
    for (int i = 0; i < 20; i++) begin
      cyc(6'(i * 7), i[0], HALTED, $sformatf("halt_hold%0d", i));
    end

    // Reset out of HALT is asynchronous
    reset = 1'b1;
    #1;
    check_regs("reset_from_halt");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Illegal opcode
    cyc(6'b00_0000, 1'b0, DEF, "boot2");
    cyc(6'b01_0110, 1'b0, DEF, "illegal_decode");
    cyc(6'b00_0010, 1'b0, ILLEG, "illegal_c1");
    cyc(6'b11_1111, 1'b1, ILLEG, "illegal_c2");

    // Sticky illegal clears on reset
    do_reset();
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_cleared: got %b expected 0", illegal);
    end
    #1;

    // Reset mid-WAIT 15
    cyc(6'b00_0000, 1'b0, DEF, "boot3");
    cyc(6'b10_1111, 1'b0, DEF, "wait15_decode");
    for (int i = 0; i < 5; i++) begin
      cyc(6'b00_0010, 1'b0, DEF, $sformatf("wait15_c%0d", i + 1));
    end
    checks++;
    if (dut.state !== WAIT || dut.cnt !== 4'd10) begin
      errors++;
      $display("FAIL wait15_count: state=%0d cnt=%0d expected state=2 cnt=10",
               dut.state, dut.cnt);
    end
    reset = 1'b1;
    #1;
    check_regs("reset_mid_wait");
    @(posedge clk);
    #2;
    reset = 1'b0;
    cyc(6'b00_0101, 1'b0, DEF, "boot4");
    cyc(6'b00_0101, 1'b0, 10'b1_0_1_1_101_1_0_0, "run_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
